// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and a registered one-cycle result strobe.
module ex_muldiv_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  req_dest_addr,
    output logic        busy,
    output logic        res_valid,
    output logic [4:0]  res_dest_addr,
    output logic [31:0] res_data
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [4:0]  dest_reg;
    logic [31:0] b_mag_reg;
    logic        neg_reg;
    logic [63:0] acc_reg, acc_next;
    logic [4:0]  cnt_reg;
    logic        res_valid_reg;
    logic [31:0] res_data_reg;
    logic [4:0]  res_dest_reg;

    // Request decode: which operands are signed, their magnitudes and the result sign
    logic        is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic        div_zero, div_ovf, special, accept;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        is_div   = req_op[2];
        a_sgn    = is_div ? ~req_op[0] : (req_op[1:0] == 2'b01 || req_op[1:0] == 2'b10);
        b_sgn    = is_div ? ~req_op[0] : (req_op[1:0] == 2'b01);
        a_neg    = a_sgn & op_a[31];
        b_neg    = b_sgn & op_b[31];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        res_neg  = (is_div && req_op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (op_b == 32'h0);
        div_ovf  = is_div && !req_op[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        accept   = req_valid && !flush && (state_reg == IDLE);
    end

    // One iteration step; acc holds {hi/remainder, lo/multiplier-or-quotient}
    logic [32:0] mul_sum, trial;
    always_comb begin
        mul_sum = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, b_mag_reg} : 33'h0);
        trial   = acc_reg[63:31] - {1'b0, b_mag_reg};
        if (op_reg[2])
            acc_next = trial[32] ? {acc_reg[62:0], 1'b0} : {trial[31:0], acc_reg[30:0], 1'b1};
        else
            acc_next = {mul_sum, acc_reg[31:1]};
    end

    logic [63:0] prod;
    logic [31:0] quot, rem, result;
    always_comb begin
        prod = neg_reg ? -acc_reg : acc_reg;
        quot = neg_reg ? -acc_reg[31:0] : acc_reg[31:0];
        rem  = neg_reg ? -acc_reg[63:32] : acc_reg[63:32];
        if (op_reg[2])
            result = op_reg[1] ? rem : quot;
        else
            result = (op_reg[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (req_valid) state_next = special ? DONE : CALC;
                CALC:    if (cnt_reg == 5'd0) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            op_reg        <= 3'h0;
            dest_reg      <= 5'h0;
            b_mag_reg     <= 32'h0;
            neg_reg       <= 1'b0;
            acc_reg       <= 64'h0;
            cnt_reg       <= 5'h0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= 32'h0;
            res_dest_reg  <= 5'h0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= req_op;
                dest_reg  <= req_dest_addr;
                b_mag_reg <= b_mag;
                neg_reg   <= special ? 1'b0 : res_neg;
                cnt_reg   <= 5'd31;
                if (div_zero)
                    acc_reg <= {op_a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    acc_reg <= {32'h0, 32'h8000_0000};
                else
                    acc_reg <= {32'h0, a_mag};
            end else if (state_reg == CALC && !flush) begin
                acc_reg <= acc_next;
                if (cnt_reg != 5'd0)
                    cnt_reg <= cnt_reg - 5'd1;
            end
            // The strobe is registered so DONE's sign fix-up has a full cycle
            res_valid_reg <= (state_reg == DONE) && !flush;
            res_data_reg  <= ((state_reg == DONE) && !flush) ? result : 32'h0;
            res_dest_reg  <= ((state_reg == DONE) && !flush) ? dest_reg : 5'h0;
        end
    end

    assign busy          = (state_reg != IDLE);
    assign res_valid     = res_valid_reg;
    assign res_data      = res_data_reg;
    assign res_dest_addr = res_dest_reg;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed RV32M cases, flush/reset aborts and
// random operations against an arithmetic reference model.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'h0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [4:0]  req_dest_addr = 5'h0;
    logic        busy, res_valid;
    logic [4:0]  res_dest_addr;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_ctrl dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .req_valid(req_valid),
        .req_op(req_op), .op_a(op_a), .op_b(op_b), .req_dest_addr(req_dest_addr),
        .busy(busy), .res_valid(res_valid), .res_dest_addr(res_dest_addr), .res_data(res_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit and 32-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        p  = 64'h0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one request from IDLE, then measure busy cycles and check the strobe
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest);
        logic [31:0] exp_data;
        int busy_cycles;
        int exp_lat;
        bit got;
        exp_data = ref_model(op, a, b);
        exp_lat  = is_special(op, a, b) ? 1 : 33;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; op_a = a; op_b = b; req_dest_addr = dest;
        @(posedge clk);
        #1 req_valid = 1'b0;
        busy_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid) begin got = 1'b1; break; end
            if (busy) busy_cycles++;
        end
        check("strobe_seen", {31'h0, got}, 32'h1);
        check("busy_cycles", busy_cycles, exp_lat);
        check("res_data", res_data, exp_data);
        check("res_dest", {27'h0, res_dest_addr}, {27'h0, dest});
        check("busy_at_strobe", {31'h0, busy}, 32'h0);
        $display("op=%0d a=%h b=%h dest=%0d -> data=%h (exp %h) latency=%0d (exp %0d)",
                 op, a, b, dest, res_data, exp_data, busy_cycles, exp_lat);
        @(negedge clk);
        check("strobe_width", {31'h0, res_valid}, 32'h0);
        check("data_idle_zero", res_data, 32'h0);
    endtask

    initial begin
        int strays;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        #2;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_valid", {31'h0, res_valid}, 32'h0);
        check("rst_data", res_data, 32'h0);
        check("rst_dest", {27'h0, res_dest_addr}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(3'd5, 32'h1234, 32'd0, 5'd7);
        run_op(3'd7, 32'h1234, 32'd0, 5'd8);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op(3'd4, 32'h8000_0000, 32'd0, 5'd11);

        // Flush on the 10th CALC cycle
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; op_a = 32'd100; op_b = 32'd200; req_dest_addr = 5'd12;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_busy_before", {31'h0, busy}, 32'h1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", {31'h0, busy}, 32'h0);
        check("flush_no_valid", {31'h0, res_valid}, 32'h0);
        $display("flush in CALC: busy=%0d res_valid=%0d", busy, res_valid);
        run_op(3'd0, 32'd3, 32'd4, 5'd13);

        // Flush during DONE of a special-case op suppresses the result
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd5; op_a = 32'h55; op_b = 32'd0; req_dest_addr = 5'd14;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        strays = 0;
        repeat (5) begin @(negedge clk); if (res_valid) strays++; end
        check("flush_done_no_result", strays, 0);
        $display("flush in DONE: stray strobes=%0d", strays);

        // Reset in the middle of CALC
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; op_a = 32'h1357_9BDF; op_b = 32'h2468_ACE0; req_dest_addr = 5'd15;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        strays = 0;
        repeat (40) begin @(negedge clk); if (res_valid || busy) strays++; end
        check("rst_abort_quiet", strays, 0);
        $display("reset in CALC: stray cycles=%0d", strays);
        run_op(3'd0, 32'd3, 32'd4, 5'd16);

        // Random operations, with operand biasing towards the divide corner cases
        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'h0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 15));
                3: r_a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
